// File: rtl/fetch_pc_ctrl.sv
// Program-counter register and instruction-fetch sequencer.
// Holds the architectural PC and fetches one instruction at a time from
// instruction memory (req/gnt/rvalid). It presents each instruction to decode
// with valid/ready and loads the next PC when decode accepts the instruction.
module fetch_pc_ctrl #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  output logic [31:0] pc,
  input  logic [31:0] npc,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_gnt,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  output logic        inst_valid,
  output logic [31:0] inst,
  input  logic        inst_ready,
  output logic        fault,
  output logic [31:0] retire_cnt
);

  typedef enum logic [1:0] {
    S_FETCH = 2'd0,
    S_WAIT  = 2'd1,
    S_HOLD  = 2'd2,
    S_FAULT = 2'd3
  } state_t;

  state_t      r_state;
  state_t      w_state_nxt;
  logic [31:0] r_pc;
  logic [31:0] r_inst;
  logic [31:0] r_retire_cnt;
  logic        r_fault;
  logic        w_accept;
  logic        w_capture;
  logic        w_npc_misaligned;

  assign w_accept         = (r_state == S_HOLD) & inst_ready;
  assign w_capture        = (r_state == S_WAIT) & imem_rvalid;
  assign w_npc_misaligned = (npc[1:0] != 2'b00);

  // Next-state logic: one outstanding fetch, FAULT is left only through rst.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_FETCH: if (imem_gnt)    w_state_nxt = S_WAIT;
      S_WAIT:  if (imem_rvalid) w_state_nxt = S_HOLD;
      S_HOLD:  if (inst_ready)  w_state_nxt = w_npc_misaligned ? S_FAULT : S_FETCH;
      S_FAULT:                  w_state_nxt = S_FAULT;
      default:                  w_state_nxt = S_FETCH;
    endcase
  end

  // State, PC, instruction and retire-counter registers; rst wins over accept.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state      <= S_FETCH;
      r_pc         <= RESET_PC;
      r_inst       <= 32'h0;
      r_retire_cnt <= 32'h0;
      r_fault      <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_fault <= (w_state_nxt == S_FAULT);
      if (w_capture) begin
        r_inst <= imem_rdata;
      end
      // The offending misaligned npc is still loaded so it is visible for debug.
      if (w_accept) begin
        r_pc         <= npc;
        r_retire_cnt <= r_retire_cnt + 32'd1;
      end
    end
  end

  // Handshake outputs are decoded from state and gated by rst so they drop at once.
  assign imem_req   = (r_state == S_FETCH) & ~rst;
  assign inst_valid = (r_state == S_HOLD) & ~rst;
  assign imem_addr  = r_pc;
  assign pc         = r_pc;
  assign inst       = r_inst;
  assign fault      = r_fault;
  assign retire_cnt = r_retire_cnt;

endmodule

// File: tb/tb_fetch_pc_ctrl.sv
// Testbench for fetch_pc_ctrl: a directed transaction driver pushes expected
// fetch addresses and instruction words into queues; a monitor pops and
// compares them whenever the DUT completes a fetch or an accept handshake.
module tb_fetch_pc_ctrl;

  localparam logic [31:0] RST_PC = 32'h0000_3000;

  logic        clk;
  logic        rst;
  logic [31:0] pc;
  logic [31:0] npc;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_gnt;
  logic        imem_rvalid;
  logic [31:0] imem_rdata;
  logic        inst_valid;
  logic [31:0] inst;
  logic        inst_ready;
  logic        fault;
  logic [31:0] retire_cnt;

  fetch_pc_ctrl #(.RESET_PC(RST_PC)) dut (
    .clk        (clk),
    .rst        (rst),
    .pc         (pc),
    .npc        (npc),
    .imem_req   (imem_req),
    .imem_addr  (imem_addr),
    .imem_gnt   (imem_gnt),
    .imem_rvalid(imem_rvalid),
    .imem_rdata (imem_rdata),
    .inst_valid (inst_valid),
    .inst       (inst),
    .inst_ready (inst_ready),
    .fault      (fault),
    .retire_cnt (retire_cnt)
  );

  int checks   = 0;
  int failures = 0;
  int gnt_hs   = 0;
  int cyc_no   = 0;
  int last_acc = 0;
  int prev_acc = 0;

  logic [31:0] exp_addr_q[$];
  logic [31:0] exp_inst_q[$];
  logic [31:0] m_pc;
  logic [31:0] m_cnt;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc_no <= cyc_no + 1;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %08h expected %08h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Monitor: score completed fetch requests and accepted instructions.
  always @(negedge clk) begin
    if (!rst) begin
      if (imem_req && imem_gnt) begin
        gnt_hs++;
        if (exp_addr_q.size() == 0) begin
          checks++; failures++;
          $display("FAIL unexpected_fetch: got addr %08h expected no request", imem_addr);
        end else begin
          chk("fetch_addr", imem_addr, exp_addr_q.pop_front());
        end
      end
      if (inst_valid && inst_ready) begin
        prev_acc = last_acc;
        last_acc = cyc_no;
        if (exp_inst_q.size() == 0) begin
          checks++; failures++;
          $display("FAIL unexpected_accept: got inst %08h expected no accept", inst);
        end else begin
          chk("accept_inst", inst, exp_inst_q.pop_front());
        end
      end
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset(input int n);
    rst = 1'b1;
    imem_gnt = 1'b0; imem_rvalid = 1'b0; imem_rdata = 32'h0;
    inst_ready = 1'b0; npc = 32'hDEAD_BEE0;
    for (int i = 0; i < n; i++) begin
      cyc();
      chk("rst_pc", pc, RST_PC);
      chk("rst_inst", inst, 32'h0);
      chk("rst_cnt", retire_cnt, 32'h0);
      chk("rst_fault", 32'(fault), 32'h0);
      chk("rst_req", 32'(imem_req), 32'h0);
      chk("rst_valid", 32'(inst_valid), 32'h0);
    end
    rst = 1'b0;
    m_pc = RST_PC;
    m_cnt = 32'h0;
    exp_addr_q.delete();
    exp_inst_q.delete();
    #1;
    chk("post_rst_req", 32'(imem_req), 32'h1);
    chk("post_rst_addr", imem_addr, RST_PC);
  endtask

  // One full fetch/accept transaction with gd/rd/yd wait cycles on gnt/rvalid/ready.
  task automatic txn(input logic [31:0] rdata, input logic [31:0] nv,
                     input int gd, input int rd, input int yd, input bit wrap);
    int hs0;
    hs0 = gnt_hs;
    exp_addr_q.push_back(m_pc);
    exp_inst_q.push_back(rdata);
    // ready asserted while nothing is valid must have no effect
    inst_ready = (gd > 0);
    for (int i = 0; i < gd; i++) begin
      chk("req_hold", 32'(imem_req), 32'h1);
      chk("addr_hold", imem_addr, m_pc);
      cyc();
    end
    imem_gnt = 1'b1;
    cyc();
    imem_gnt = 1'b0;
    for (int i = 0; i < rd; i++) begin
      chk("wait_idle", {30'h0, imem_req, inst_valid}, 32'h0);
      imem_rdata = $urandom;
      cyc();
    end
    imem_rvalid = 1'b1;
    imem_rdata = rdata;
    cyc();
    imem_rvalid = 1'b0;
    imem_rdata = 32'h0;
    inst_ready = 1'b0;
    for (int i = 0; i < yd; i++) begin
      chk("hold_valid", 32'(inst_valid), 32'h1);
      chk("hold_inst", inst, rdata);
      chk("hold_pc", pc, m_pc);
      cyc();
    end
    if (wrap) begin
      force dut.r_retire_cnt = 32'hFFFF_FFFF;
      #1;
      release dut.r_retire_cnt;
      m_cnt = 32'hFFFF_FFFF;
    end
    chk("acc_valid", 32'(inst_valid), 32'h1);
    inst_ready = 1'b1;
    npc = nv;
    cyc();
    inst_ready = 1'b0;
    npc = 32'hDEAD_BEE0;
    m_pc = nv;
    m_cnt = m_cnt + 32'd1;
    chk("pc_after", pc, m_pc);
    chk("cnt_after", retire_cnt, m_cnt);
    chk("one_request", 32'(gnt_hs - hs0), 32'h1);
    chk("fault_after", 32'(fault), 32'(nv[1:0] != 2'b00));
    if (nv[1:0] == 2'b00) begin
      chk("next_req", 32'(imem_req), 32'h1);
      chk("next_addr", imem_addr, nv);
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1;
    imem_gnt = 1'b0; imem_rvalid = 1'b0; imem_rdata = 32'h0;
    inst_ready = 1'b0; npc = 32'hDEAD_BEE0;
    m_pc = RST_PC; m_cnt = 32'h0;

    // Reset and first fetch at minimum latency
    do_reset(2);
    txn(32'h2008_0005, 32'h0000_3004, 0, 0, 0, 1'b0);

    // Back-pressure on all three handshakes: period 12
    txn(32'h1234_5678, 32'h0000_3008, 3, 2, 4, 1'b0);
    chk("period_12", 32'(last_acc - prev_acc), 32'd12);

    // Branch and jump redirects
    txn(32'hAAAA_0001, 32'h0000_3004, 0, 1, 0, 1'b0);
    txn(32'hAAAA_0002, 32'h0000_3020, 1, 0, 1, 1'b0);
    txn(32'hAAAA_0003, 32'h0040_0000, 0, 0, 0, 1'b0);
    // Self-loop refetches the same address
    txn(32'hBBBB_0004, 32'h0040_0000, 0, 0, 2, 1'b0);
    txn(32'hBBBB_0005, 32'h0000_3000, 0, 0, 0, 1'b0);

    // Counter wrap
    txn(32'hCCCC_0006, 32'h0000_3004, 0, 0, 1, 1'b1);
    chk("wrap_cnt", retire_cnt, 32'h0);

    // Misaligned npc: sticky fault, no activity while handshakes toggle
    txn(32'hDDDD_0007, 32'h0000_3006, 0, 0, 0, 1'b0);
    for (int i = 0; i < 20; i++) begin
      imem_gnt = i[0]; imem_rvalid = i[1]; inst_ready = 1'b1;
      chk("fault_sticky", 32'(fault), 32'h1);
      chk("fault_pc", pc, 32'h0000_3006);
      chk("fault_quiet", {30'h0, imem_req, inst_valid}, 32'h0);
      cyc();
    end
    do_reset(1);
    chk("fault_cleared", 32'(fault), 32'h0);

    // Reset mid-WAIT aborts the transaction
    txn(32'hEEEE_0008, 32'h0000_3010, 0, 0, 0, 1'b0);
    exp_addr_q.push_back(m_pc);
    imem_gnt = 1'b1;
    cyc();
    imem_gnt = 1'b0;
    chk("in_wait", {30'h0, imem_req, inst_valid}, 32'h0);
    do_reset(1);
    chk("abort_valid", 32'(inst_valid), 32'h0);
    chk("abort_cnt", retire_cnt, 32'h0);

    // Normal operation resumes after abort
    txn(32'hF00D_0009, 32'h0000_3004, 1, 1, 1, 1'b0);

    chk("addr_q_empty", 32'(exp_addr_q.size()), 32'h0);
    chk("inst_q_empty", 32'(exp_inst_q.size()), 32'h0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
